// File: rtl/layer_cfg_pkg.sv
// Shared definitions for the layer configuration loader: field widths and
// offsets inside the 128-bit CFG word, the sequencer state encoding, and the
// helpers that build the word and judge whether the requested geometry fits.
package layer_cfg_pkg;

  // Chain geometry
  localparam int CHAIN_LEN  = 128;
  localparam int IDX_WIDTH  = 7;
  localparam int NNEURON    = 16;
  localparam int VTH_WIDTH  = 5;

  // Field widths inside the CFG word
  localparam int HW_WIDTH   = 5;
  localparam int T_WIDTH    = 5;
  localparam int D1_WIDTH   = 5;
  localparam int D2_WIDTH   = 9;
  localparam int NCFG_WIDTH = 96;
  localparam int TPD_WIDTH  = 4;

  // Field LSB positions inside the CFG word (bit 0 leaves first)
  localparam int HW_LSB     = 0;
  localparam int T_LSB      = 5;
  localparam int D1_LSB     = 10;
  localparam int D2_LSB     = 15;
  localparam int NCFG_LSB   = 24;
  localparam int TPD_LSB    = 120;
  localparam int PD_MEM_BIT = 124;
  localparam int PD_CIM_BIT = 125;
  localparam int BP_BIT     = 126;
  localparam int SWP_BIT    = 127;

  // Legal operating envelope
  localparam logic [4:0]  HW_MIN = 5'd4;
  localparam logic [5:0]  T_MAX  = 6'd32;
  localparam logic [11:0] D2_MAX = 12'd511;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_FAIL   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // D2 = (HW-3)*T-1, kept wide enough that any 5-bit HW / 6-bit T product
  // is representable so the range check sees the true value.
  function automatic logic [11:0] calc_d2(input logic [4:0] hw, input logic [5:0] t);
    logic [11:0] span;
    logic [11:0] prod;
    span = {7'd0, hw} - 12'd3;
    prod = span * {6'd0, t};
    return prod - 12'd1;
  endfunction

  // True when the requested geometry can be encoded in the chain.
  function automatic logic range_ok(input logic [4:0] hw, input logic [5:0] t);
    logic [11:0] d2;
    d2 = calc_d2(hw, t);
    return (hw >= HW_MIN) && (t != 6'd0) && (t <= T_MAX) && (d2 <= D2_MAX);
  endfunction

  // Assemble the full CFG word from the parallel fields.
  function automatic logic [CHAIN_LEN-1:0] pack_word(
    input logic [4:0]                     hw,
    input logic [5:0]                     t,
    input logic [NNEURON*VTH_WIDTH-1:0]   vth,
    input logic [NNEURON-1:0]             neur_dis,
    input logic [TPD_WIDTH-1:0]           tpd,
    input logic                           pd_en_mem,
    input logic                           pd_en_cim,
    input logic                           bp,
    input logic                           swp
  );
    logic [CHAIN_LEN-1:0] w;
    logic [11:0]          d2;
    logic [5:0]           t_m1;
    logic [4:0]           hw_m1;
    d2    = calc_d2(hw, t);
    t_m1  = t - 6'd1;
    hw_m1 = hw - 5'd1;
    w     = '0;
    w[HW_LSB +: HW_WIDTH]     = hw_m1;
    w[T_LSB +: T_WIDTH]       = t_m1[T_WIDTH-1:0];
    w[D1_LSB +: D1_WIDTH]     = t_m1[D1_WIDTH-1:0];
    w[D2_LSB +: D2_WIDTH]     = d2[D2_WIDTH-1:0];
    w[NCFG_LSB +: NCFG_WIDTH] = {neur_dis, vth};
    w[TPD_LSB +: TPD_WIDTH]   = tpd;
    w[PD_MEM_BIT]             = pd_en_mem;
    w[PD_CIM_BIT]             = pd_en_cim;
    w[BP_BIT]                 = bp;
    w[SWP_BIT]                = swp;
    return w;
  endfunction

endpackage

// File: rtl/layer_cfg_loader.sv
// Builds the 128-bit layer CFG word at START and shifts it out LSB first on
// CFG_WE/CFG_D. An optional second pass re-shifts the same word while the
// bits returning on CFG_Q are compared, so the chain ends up holding the
// word again and the first corrupted bit position is reported.
//
// Handshake: START is a one-cycle request honoured only while idle (BUSY=0);
// all fields and VERIFY_EN are captured on that cycle. BUSY rises the cycle
// after an accepted START and falls in the cycle DONE pulses. ERR/ERR_IDX are
// valid from the DONE cycle and hold until the next accepted START or RST.
//
// All outputs are registered. The FSM issues bit k in the cycle it sits at
// count k, so the serial interface trails the state by one cycle.
module layer_cfg_loader
  import layer_cfg_pkg::*;
(
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          START,
  input  logic                          VERIFY_EN,
  input  logic [4:0]                    HW,
  input  logic [5:0]                    T,
  input  logic [NNEURON*VTH_WIDTH-1:0]  VTH,
  input  logic [NNEURON-1:0]            NEUR_DIS,
  input  logic [TPD_WIDTH-1:0]          TPD,
  input  logic                          PD_EN_MEM,
  input  logic                          PD_EN_CIM,
  input  logic                          BP,
  input  logic                          SWP,
  output logic                          CFG_WE,
  output logic                          CFG_D,
  input  logic                          CFG_Q,
  output logic                          BUSY,
  output logic                          DONE,
  output logic                          ERR,
  output logic [IDX_WIDTH-1:0]          ERR_IDX,
  output logic [2:0]                    DBG_STATE
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(CHAIN_LEN - 1);

  state_t                 state;
  state_t                 state_next;
  logic [IDX_WIDTH-1:0]   cnt;
  logic [IDX_WIDTH-1:0]   cnt_next;
  logic [CHAIN_LEN-1:0]   w_reg;
  logic [CHAIN_LEN-1:0]   word_in;
  logic                   verify_reg;
  logic                   load_w;
  logic                   start_ok;

  // Read-back tracking: chk_en marks a CFG_WE cycle belonging to the verify
  // pass, chk_idx is the bit index being shifted in that cycle.
  logic                   chk_en;
  logic                   chk_en_next;
  logic [IDX_WIDTH-1:0]   chk_idx;
  logic [IDX_WIDTH-1:0]   chk_idx_next;
  logic                   mismatch;

  logic                   we_next;
  logic                   d_next;
  logic                   busy_next;
  logic                   done_next;
  logic                   err_next;
  logic [IDX_WIDTH-1:0]   err_idx_next;

  assign word_in   = pack_word(HW, T, VTH, NEUR_DIS, TPD, PD_EN_MEM, PD_EN_CIM, BP, SWP);
  assign start_ok  = range_ok(HW, T);
  assign DBG_STATE = state;

  // CFG_D currently carries W[chk_idx]; the chain should be returning the
  // same bit, since it was loaded with W exactly 128 shifts earlier.
  assign mismatch  = chk_en && (CFG_Q != CFG_D) && !ERR;

  // Next-state, counter and next-output decode.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    load_w       = 1'b0;
    we_next      = 1'b0;
    d_next       = 1'b0;
    busy_next    = BUSY;
    done_next    = 1'b0;
    err_next     = ERR;
    err_idx_next = ERR_IDX;
    chk_en_next  = 1'b0;
    chk_idx_next = cnt;

    // Only the first mismatch of a pass is recorded.
    if (mismatch) begin
      err_next     = 1'b1;
      err_idx_next = chk_idx;
    end

    unique case (state)
      ST_IDLE: begin
        if (START) begin
          load_w       = 1'b1;
          busy_next    = 1'b1;
          cnt_next     = '0;
          err_idx_next = '0;
          if (start_ok) begin
            err_next   = 1'b0;
            state_next = ST_LOAD;
          end else begin
            err_next   = 1'b1;
            state_next = ST_FAIL;
          end
        end
      end

      ST_LOAD: begin
        we_next  = 1'b1;
        d_next   = w_reg[cnt];
        cnt_next = cnt + 1'b1;
        if (cnt == LAST_IDX) begin
          state_next = verify_reg ? ST_VERIFY : ST_FINISH;
        end
      end

      ST_VERIFY: begin
        we_next      = 1'b1;
        d_next       = w_reg[cnt];
        chk_en_next  = 1'b1;
        chk_idx_next = cnt;
        cnt_next     = cnt + 1'b1;
        if (cnt == LAST_IDX) begin
          state_next = ST_FINISH;
        end
      end

      // A range error never touches the chain; it just reports completion.
      ST_FAIL, ST_FINISH: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register and bit counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Capture the assembled word and the verify request on an accepted START.
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_reg      <= '0;
      verify_reg <= 1'b0;
    end else if (load_w) begin
      w_reg      <= word_in;
      verify_reg <= VERIFY_EN;
    end
  end

  // Registered serial interface, status outputs and read-back tracking.
  always_ff @(posedge CLK) begin
    if (RST) begin
      CFG_WE  <= 1'b0;
      CFG_D   <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
      ERR_IDX <= '0;
      chk_en  <= 1'b0;
      chk_idx <= '0;
    end else begin
      CFG_WE  <= we_next;
      CFG_D   <= d_next;
      BUSY    <= busy_next;
      DONE    <= done_next;
      ERR     <= err_next;
      ERR_IDX <= err_idx_next;
      chk_en  <= chk_en_next;
      chk_idx <= chk_idx_next;
    end
  end

endmodule

// File: tb/tb_layer_cfg_loader.sv
// Bench for layer_cfg_loader: a 128-flop chain model sits on the serial
// port, the driver pushes the expected bit stream and completion record for
// each request, and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_layer_cfg_loader;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        VERIFY_EN;
  logic [4:0]  HW;
  logic [5:0]  T;
  logic [79:0] VTH;
  logic [15:0] NEUR_DIS;
  logic [3:0]  TPD;
  logic        PD_EN_MEM;
  logic        PD_EN_CIM;
  logic        BP;
  logic        SWP;
  logic        CFG_WE;
  logic        CFG_D;
  logic        CFG_Q;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [6:0]  ERR_IDX;
  logic [2:0]  DBG_STATE;

  always #5 CLK = ~CLK;

  layer_cfg_loader dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .VERIFY_EN (VERIFY_EN),
    .HW        (HW),
    .T         (T),
    .VTH       (VTH),
    .NEUR_DIS  (NEUR_DIS),
    .TPD       (TPD),
    .PD_EN_MEM (PD_EN_MEM),
    .PD_EN_CIM (PD_EN_CIM),
    .BP        (BP),
    .SWP       (SWP),
    .CFG_WE    (CFG_WE),
    .CFG_D     (CFG_D),
    .CFG_Q     (CFG_Q),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR),
    .ERR_IDX   (ERR_IDX),
    .DBG_STATE (DBG_STATE)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- chain model ----------------
  int           cyc        = 0;
  int           we_total   = 0;
  int           we_base    = 0;
  logic [127:0] chain      = '0;
  logic [127:0] fault_bits = '0;
  logic [127:0] cap_word   = '0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (CFG_WE) begin
      we_total <= we_total + 1;
      chain    <= {chain[126:0], CFG_D};
    end
  end

  // Output end of the chain; selected read-back bits are inverted to model
  // a corrupted flop as seen during the second pass.
  always_comb begin
    int k;
    k     = we_total - we_base - 128;
    CFG_Q = chain[127];
    if (CFG_WE && k >= 0 && k < 128) CFG_Q = chain[127] ^ fault_bits[k];
  end

  function automatic logic [127:0] chain_word();
    logic [127:0] w;
    for (int j = 0; j < 128; j++) w[j] = chain[127-j];
    return w;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [127:0] put(input logic [127:0] w, input int lsb, input int width, input int val);
    logic [127:0] r;
    r = w;
    for (int b = 0; b < width; b++) r[lsb+b] = val[b];
    return r;
  endfunction

  function automatic logic [127:0] ref_word(input int hw, input int t, input logic [79:0] vth,
                                            input logic [15:0] nd, input int tpd, input logic [3:0] fl);
    logic [127:0] w;
    w = '0;
    w = put(w, 0, 5, hw - 1);
    w = put(w, 5, 5, t - 1);
    w = put(w, 10, 5, t - 1);
    w = put(w, 15, 9, (hw - 3) * t - 1);
    for (int i = 0; i < 80; i++) w[24+i] = vth[i];
    for (int i = 0; i < 16; i++) w[104+i] = nd[i];
    w = put(w, 120, 4, tpd);
    for (int i = 0; i < 4; i++) w[124+i] = fl[i];
    return w;
  endfunction

  function automatic bit geometry_bad(input int hw, input int t);
    return (hw < 4) || (t == 0) || (t > 32) || ((hw - 3) * t - 1 > 511);
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    int           issue_cyc;
    int           lat;
    logic         err;
    logic [6:0]   idx;
    logic         chk_chain;
    logic [127:0] w;
  } exp_done_t;

  logic [0:0] exp_q[$];
  exp_done_t  done_q[$];

  // Monitor: every CFG_WE cycle consumes one expected bit, every DONE pulse
  // consumes one completion record.
  always @(negedge CLK) begin
    int        k;
    logic [0:0] b;
    exp_done_t e;
    if (!RST) begin
      if (CFG_WE) begin
        k = we_total - we_base;
        if (k >= 0 && k < 128) cap_word[k] = CFG_D;
        if (exp_q.size() == 0) begin
          check("cfg_we_unexpected", CFG_WE, 1'b0);
        end else begin
          b = exp_q.pop_front();
          check("cfg_d_bit", CFG_D, b);
          check("busy_during_shift", BUSY, 1'b1);
        end
      end
      if (DONE) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", DONE, 1'b0);
        end else begin
          e = done_q.pop_front();
          check("done_latency", cyc - e.issue_cyc, e.lat);
          check("err_at_done", ERR, e.err);
          check("err_idx_at_done", ERR_IDX, e.idx);
          check("busy_at_done", BUSY, 1'b0);
          check("stream_length", exp_q.size(), 0);
          if (e.chk_chain) check("chain_holds_w", chain_word(), e.w);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_fields(input int hw, input int t, input logic [79:0] vth, input logic [15:0] nd,
                              input int tpd, input logic [3:0] fl, input logic ve);
    HW        = 5'(hw);
    T         = 6'(t);
    VTH       = vth;
    NEUR_DIS  = nd;
    TPD       = 4'(tpd);
    PD_EN_MEM = fl[0];
    PD_EN_CIM = fl[1];
    BP        = fl[2];
    SWP       = fl[3];
    VERIFY_EN = ve;
  endtask

  // Issue an accepted request and push its expected stream and completion.
  task automatic issue(input int hw, input int t, input logic [79:0] vth, input logic [15:0] nd,
                       input int tpd, input logic [3:0] fl, input logic ve);
    exp_done_t    e;
    logic [127:0] w;
    bit           bad;
    int           first;
    @(negedge CLK);
    drive_fields(hw, t, vth, nd, tpd, fl, ve);
    START   = 1'b1;
    we_base = we_total;
    bad     = geometry_bad(hw, t);
    w       = ref_word(hw, t, vth, nd, tpd, fl);
    first   = -1;
    if (ve) begin
      for (int i = 127; i >= 0; i--) if (fault_bits[i]) first = i;
    end
    e.issue_cyc = cyc;
    e.w         = w;
    e.chk_chain = !bad;
    if (bad) begin
      e.lat = 2;
      e.err = 1'b1;
      e.idx = 7'd0;
    end else begin
      e.lat = ve ? 258 : 130;
      e.err = (first >= 0);
      e.idx = (first >= 0) ? 7'(first) : 7'd0;
      for (int i = 0; i < 128; i++) exp_q.push_back(w[i]);
      if (ve) for (int i = 0; i < 128; i++) exp_q.push_back(w[i]);
    end
    done_q.push_back(e);
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_q.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (done_q.size() != 0) begin
      check("done_timeout", done_q.size(), 0);
      done_q.delete();
      exp_q.delete();
    end
  endtask

  task automatic wait_we(input int target, input int budget);
    int n;
    n = 0;
    while ((we_total - we_base) < target && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if ((we_total - we_base) < target) check("we_count_timeout", we_total - we_base, target);
  endtask

  // ---------------- stimulus ----------------
  logic [79:0] vth10;
  logic [95:0] rnd96;
  logic [79:0] rvth;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vth10 = {16{5'd10}};
    RST   = 1'b1;
    START = 1'b0;
    drive_fields(16, 8, vth10, 16'h0, 10, 4'b0011, 1'b0);
    repeat (3) @(negedge CLK);
    check("rst_cfg_we", CFG_WE, 1'b0);
    check("rst_cfg_d", CFG_D, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_done", DONE, 1'b0);
    check("rst_err", ERR, 1'b0);
    check("rst_err_idx", ERR_IDX, 7'd0);
    check("rst_state", DBG_STATE, 3'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Plain load of the reference configuration.
    issue(16, 8, vth10, 16'h0, 10, 4'b0011, 1'b0);
    wait_done(400);
    check("field_hw", cap_word[4:0], 5'd15);
    check("field_t", cap_word[9:5], 5'd7);
    check("field_d1", cap_word[14:10], 5'd7);
    check("field_d2", cap_word[23:15], 9'd103);
    check("field_vth0", cap_word[27:24], 4'd10);

    // Same configuration with read-back over an ideal chain.
    issue(16, 8, vth10, 16'h0, 10, 4'b0011, 1'b1);
    wait_done(400);

    // Read-back with two corrupted bits: the first one is reported.
    fault_bits     = '0;
    fault_bits[40] = 1'b1;
    fault_bits[90] = 1'b1;
    issue(16, 8, vth10, 16'h0, 10, 4'b0011, 1'b1);
    wait_done(400);
    repeat (3) @(negedge CLK);
    check("err_sticky", ERR, 1'b1);
    check("err_idx_sticky", ERR_IDX, 7'd40);
    fault_bits = '0;

    // Range errors: D2 too large, then HW too small.
    issue(31, 32, vth10, 16'h0, 10, 4'b0011, 1'b1);
    wait_done(20);
    issue(3, 8, vth10, 16'h0, 10, 4'b0011, 1'b0);
    wait_done(20);

    // Reset in the middle of a load, then a clean reload with read-back.
    issue(16, 8, vth10, 16'h0, 10, 4'b0011, 1'b0);
    wait_we(60, 200);
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_cfg_we", CFG_WE, 1'b0);
    check("midrst_busy", BUSY, 1'b0);
    check("midrst_err", ERR, 1'b0);
    check("midrst_state", DBG_STATE, 3'd0);
    exp_q.delete();
    done_q.delete();
    RST = 1'b0;
    issue(16, 8, vth10, 16'h5a5a, 7, 4'b1100, 1'b1);
    wait_done(400);

    // START while busy must not disturb the running load.
    issue(16, 8, vth10, 16'h0, 10, 4'b0011, 1'b0);
    wait_we(10, 200);
    HW    = 5'd5;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done(400);
    check("ignored_start_hw", cap_word[4:0], 5'd15);

    // Randomised configurations, legal and illegal, with random faults.
    for (int it = 0; it < 10; it++) begin
      int   hw;
      int   t;
      int   nf;
      logic ve;
      hw    = $urandom_range(3, 31);
      t     = $urandom_range(0, 34);
      rnd96 = {$urandom(), $urandom(), $urandom()};
      rvth  = rnd96[79:0];
      ve    = 1'($urandom_range(0, 1));
      fault_bits = '0;
      nf    = ve ? $urandom_range(0, 2) : 0;
      for (int f = 0; f < nf; f++) fault_bits[$urandom_range(0, 127)] = 1'b1;
      issue(hw, t, rvth, 16'($urandom()), $urandom_range(0, 15), 4'($urandom_range(0, 15)), ve);
      wait_done(400);
    end
    fault_bits = '0;

    repeat (4) @(negedge CLK);
    check("queues_drained", exp_q.size() + done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
